// File: rtl/inv_rot_pkg.sv
// Shared types and defaults for the inverse planar rotation block and its multiplier.
package inv_rot_pkg;

  localparam int unsigned Q_FRAC_DEF  = 13;
  localparam int unsigned MUL_LAT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    ACC    = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Product index k: which operand pair feeds the multiplier.
  typedef enum logic [1:0] {
    SEL_AX_COS = 2'd0,
    SEL_AY_SIN = 2'd1,
    SEL_AX_SIN = 2'd2,
    SEL_AY_COS = 2'd3
  } prod_sel_t;

endpackage

// File: rtl/seq_mult16.sv
// Signed 16x16 sequential shift-add multiplier; mdone pulses MUL_LAT cycles after mstart.
module seq_mult16
  import inv_rot_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mstart,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p,
  output logic        mdone
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  logic [CW-1:0] cnt;
  logic          run;
  logic [4:0]    step;
  logic [31:0]   mcand;
  logic [15:0]   mplier;

  assign mdone = run && (cnt == '0);

  // Bit 0 is handled at the load edge, bits 1..15 on the following edges;
  // bit 15 carries weight -2^15, so its partial product is subtracted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      step   <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (mstart) begin
      p      <= b[0] ? {{16{a[15]}}, a} : '0;
      mcand  <= {{15{a[15]}}, a, 1'b0};
      mplier <= {1'b0, b[15:1]};
      step   <= 5'd1;
      cnt    <= CW'(MUL_LAT - 1);
      run    <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
      if (step != 5'd16) begin
        if (mplier[0]) p <= (step == 5'd15) ? p - mcand : p + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        step   <= step + 5'd1;
      end
    end
  end

endmodule

// File: rtl/inv_rot_transform.sv
// Inverse planar rotation: world-frame (ax, ay, az) to body frame via Q2.13 sin/cos,
// four products computed on one shared sequential multiplier.
module inv_rot_transform
  import inv_rot_pkg::*;
#(
  parameter int unsigned Q_FRAC  = Q_FRAC_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  input  logic [15:0] az,
  input  logic [15:0] sin_q,
  input  logic [15:0] cos_q,
  output logic [31:0] bx,
  output logic [31:0] by,
  output logic [31:0] bz,
  output logic        busy,
  output logic        done
);

  state_t    state, state_nxt;
  prod_sel_t k;
  logic [1:0] k_inc;

  logic [15:0] ax_l, ay_l, az_l, sin_l, cos_l;
  logic [15:0] op_a, op_b;
  logic        mstart, mdone;
  logic [31:0] p;

  logic signed [33:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt, p_ext, sh_x, sh_y;

  seq_mult16 #(.MUL_LAT(MUL_LAT)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .mstart (mstart),
    .a      (op_a),
    .b      (op_b),
    .p      (p),
    .mdone  (mdone)
  );

  assign mstart = (state == ISSUE);
  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);
  assign k_inc  = k + 2'd1;
  assign p_ext  = signed'({{2{p[31]}}, p});
  assign sh_x   = acc_x_nxt >>> Q_FRAC;
  assign sh_y   = acc_y_nxt >>> Q_FRAC;

  always_comb begin
    op_a = ax_l;
    op_b = cos_l;
    case (k)
      SEL_AX_COS: begin op_a = ax_l; op_b = cos_l; end
      SEL_AY_SIN: begin op_a = ay_l; op_b = sin_l; end
      SEL_AX_SIN: begin op_a = ax_l; op_b = sin_l; end
      SEL_AY_COS: begin op_a = ay_l; op_b = cos_l; end
      default:    begin op_a = ax_l; op_b = cos_l; end
    endcase
  end

  always_comb begin
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    case (k)
      SEL_AX_COS, SEL_AY_SIN: acc_x_nxt = acc_x + p_ext;
      SEL_AX_SIN:             acc_y_nxt = acc_y - p_ext;
      SEL_AY_COS:             acc_y_nxt = acc_y + p_ext;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mdone) state_nxt = ACC;
      ACC:     state_nxt = (k == SEL_AY_COS) ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs load from the final accumulator values on the edge into FINISH,
  // so they are already valid in the cycle done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= SEL_AX_COS;
      ax_l  <= '0;
      ay_l  <= '0;
      az_l  <= '0;
      sin_l <= '0;
      cos_l <= '0;
      acc_x <= '0;
      acc_y <= '0;
      bx    <= '0;
      by    <= '0;
      bz    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ax_l  <= ax;
            ay_l  <= ay;
            az_l  <= az;
            sin_l <= sin_q;
            cos_l <= cos_q;
            acc_x <= '0;
            acc_y <= '0;
            k     <= SEL_AX_COS;
          end
        end
        ACC: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          if (k == SEL_AY_COS) begin
            bx <= sh_x[31:0];
            by <= sh_y[31:0];
            bz <= {{16{az_l[15]}}, az_l};
          end else begin
            k <= prod_sel_t'(k_inc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_rot_transform.sv
// Directed self-checking bench for inv_rot_transform with hand-computed expectations.
module tb_inv_rot_transform;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ax = '0, ay = '0, az = '0, sin_q = '0, cos_q = '0;
  logic [31:0] bx, by, bz;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  inv_rot_transform #(.Q_FRAC(13), .MUL_LAT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ax    (ax),
    .ay    (ay),
    .az    (az),
    .sin_q (sin_q),
    .cos_q (cos_q),
    .bx    (bx),
    .by    (by),
    .bz    (bz),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic set_inputs(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic [15:0] s, input logic [15:0] c);
    ax = x; ay = y; az = z; sin_q = s; cos_q = c;
  endtask

  // One request; inputs are scrambled right after the accept edge to prove latching.
  task automatic run_op(input string tag,
                        input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [15:0] s, input logic [15:0] c,
                        input int exp_bx, input int exp_by, input int exp_bz);
    int cyc;
    @(negedge clk);
    set_inputs(x, y, z, s, c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    set_inputs(16'h5a5a, 16'ha5a5, 16'h1234, 16'h7fff, 16'h8001);
    cyc = 0;
    while (cyc < 200 && !done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq({tag, "_busy_c1"}, 32'(busy), 32'd1);
    end
    check_eq({tag, "_done_cycle"}, cyc, 73);
    check_eq({tag, "_bx"}, bx, exp_bx);
    check_eq({tag, "_by"}, by, exp_by);
    check_eq({tag, "_bz"}, bz, exp_bz);
    @(negedge clk);
    check_eq({tag, "_busy_c74"}, 32'(busy), 32'd0);
    check_eq({tag, "_done_c74"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_cyc[$];
    int cyc;
    int ndone;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_bx", bx, 32'd0);
    check_eq("rst_by", by, 32'd0);
    check_eq("rst_bz", bz, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("identity", 16'd1000, -16'sd500, 16'd77, 16'd0, 16'd8192, 1000, -500, 77);
    run_op("rot90", 16'd1000, 16'd2000, -16'sd3, 16'd8192, 16'd0, 2000, -1000, -3);
    run_op("rot45", 16'd8192, 16'd8192, 16'd0, 16'd5793, 16'd5793, 11586, 0, 0);
    run_op("floor", -16'sd1, 16'd0, 16'd1, 16'd0, 16'd8191, -1, 0, 1);
    run_op("extreme", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 262144, 0, -32768);

    // Start pulses in cycle 5 and in the done cycle must be ignored.
    @(negedge clk);
    set_inputs(16'd1000, 16'd2000, 16'd9, 16'd8192, 16'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check_eq("ign_done_cycle", c, 73);
        check_eq("ign_bx", bx, 2000);
        check_eq("ign_by", by, -1000);
        check_eq("ign_bz", bz, 9);
      end
      if (c == 74) check_eq("ign_busy_c74", 32'(busy), 32'd0);
      if (c == 75) check_eq("ign_busy_c75", 32'(busy), 32'd0);
      if (c == 5 || c == 73) begin
        set_inputs(16'd7777, -16'sd1234, 16'd55, 16'd100, 16'd200);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check_eq("ign_ndone", ndone, 1);

    // Start held high: one done every 74 cycles.
    @(negedge clk);
    set_inputs(16'd1000, -16'sd500, 16'd77, 16'd0, 16'd8192);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 222; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(c);
        check_eq("b2b_bx", bx, 1000);
        check_eq("b2b_by", by, -500);
      end
    end
    start = 1'b0;
    check_eq("b2b_ndone", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check_eq("b2b_d0", done_cyc[0], 73);
      check_eq("b2b_d1", done_cyc[1], 147);
      check_eq("b2b_d2", done_cyc[2], 221);
    end
    @(negedge clk);
    check_eq("b2b_idle", 32'(busy), 32'd0);

    // Reset in cycle 30 of an operation.
    @(negedge clk);
    set_inputs(16'd8192, 16'd8192, 16'd5, 16'd5793, 16'd5793);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_bx", bx, 32'd0);
    check_eq("mid_rst_by", by, 32'd0);
    check_eq("mid_rst_bz", bz, 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) cyc++;
    end
    check_eq("mid_no_done", ndone, 0);
    check_eq("mid_no_busy", cyc, 0);
    run_op("post_rst", 16'd1000, -16'sd500, 16'd77, 16'd0, 16'd8192, 1000, -500, 77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
